// File: rtl/xbar_bank_arb.sv
// ============================================================================
// Module   : xbar_bank_arb
// Brief    : 3-channel round-robin arbiter feeding a bank request FIFO.
//            Define XBAR_BANK_ARB_PERF_CNT_EN to add per-channel grant counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xbar_bank_arb #(
  parameter int ENTRY_ID_W = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2:0]                           ch_valid,
  input  logic [3*ENTRY_ID_W-1:0]              ch_entry_id,
  output logic [2:0]                           ch_grant,
  output logic                                 bank_valid,
  input  logic                                 bank_ready,
  output logic [1:0]                           bank_ch,
  output logic [ENTRY_ID_W-1:0]                bank_entry_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
`ifdef XBAR_BANK_ARB_PERF_CNT_EN
  ,
  output logic [3*16-1:0]                      grant_cnt
`endif
);

  localparam int C_AW = $clog2(FIFO_DEPTH);
  localparam int C_CW = $clog2(FIFO_DEPTH+1);
  localparam int C_EW = ENTRY_ID_W + 2;
  localparam logic [C_CW-1:0] C_FULL = C_CW'(FIFO_DEPTH);

  logic [1:0]            rr_q;
  logic [C_AW-1:0]       wr_q;
  logic [C_AW-1:0]       rd_q;
  logic [C_CW-1:0]       count_q;
  logic [C_CW-1:0]       count_d;
  logic [C_EW-1:0]       mem_q [FIFO_DEPTH];

  logic                  w_hit;
  logic [1:0]            w_sel;
  logic [ENTRY_ID_W-1:0] w_id;
  logic                  w_push;
  logic                  w_pop;

  // Rotating search from rr_q; the first requester found wins.
  always_comb begin
    logic [2:0] c;
    w_hit = 1'b0;
    w_sel = 2'd0;
    c     = 3'd0;
    for (int k = 0; k < 3; k++) begin
      c = {1'b0, rr_q} + 3'(k);
      if (c >= 3'd3) c = c - 3'd3;
      if (!w_hit && ch_valid[c[1:0]]) begin
        w_hit = 1'b1;
        w_sel = c[1:0];
      end
    end
  end

  assign ch_grant = (w_hit && (count_q != C_FULL) && !rst) ? (3'b001 << w_sel) : 3'b000;
  assign w_push   = |(ch_valid & ch_grant);
  assign w_id     = ch_entry_id[w_sel*ENTRY_ID_W +: ENTRY_ID_W];

  assign bank_valid                = (count_q != '0);
  assign w_pop                     = bank_valid & bank_ready;
  assign {bank_ch, bank_entry_id}  = mem_q[rd_q];
  assign fifo_count                = count_q;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= 2'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_push) begin
        rr_q <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
        wr_q <= wr_q + 1'b1;
      end
      if (w_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left unreset; bank_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= {w_sel, w_id};
  end

`ifdef XBAR_BANK_ARB_PERF_CNT_EN
  for (genvar i = 0; i < 3; i++) begin : g_perf_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= 16'h0000;
      end else if (ch_valid[i] && ch_grant[i] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'h0001;
      end
    end
    assign grant_cnt[i*16 +: 16] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_xbar_bank_arb.sv
// ============================================================================
// Module   : tb_xbar_bank_arb
// Brief    : Scoreboard bench for xbar_bank_arb; grant_cnt exercised when
//            XBAR_BANK_ARB_PERF_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xbar_bank_arb;

  logic        clk;
  logic        rst;
  logic [2:0]  ch_valid;
  logic [11:0] ch_entry_id;
  logic [2:0]  ch_grant;
  logic        bank_valid;
  logic        bank_ready;
  logic [1:0]  bank_ch;
  logic [3:0]  bank_entry_id;
  logic [2:0]  fifo_count;
`ifdef XBAR_BANK_ARB_PERF_CNT_EN
  logic [47:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q [$];

  xbar_bank_arb #(.ENTRY_ID_W(4), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_valid      (ch_valid),
    .ch_entry_id   (ch_entry_id),
    .ch_grant      (ch_grant),
    .bank_valid    (bank_valid),
    .bank_ready    (bank_ready),
    .bank_ch       (bank_ch),
    .bank_entry_id (bank_entry_id),
    .fifo_count    (fifo_count)
`ifdef XBAR_BANK_ARB_PERF_CNT_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (bank_valid === 1'b1 && bank_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bank_unexpected actual=%0h required=none", {bank_ch, bank_entry_id});
      end else begin
        chk("bank_head", 64'({bank_ch, bank_entry_id}), 64'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; ec < 0 skips the occupancy check.
  task automatic cyc(input logic [2:0] v, input logic [11:0] ids, input logic rdy,
                     input logic [2:0] eg, input int ec);
    @(posedge clk);
    #1;
    ch_valid    = v;
    ch_entry_id = ids;
    bank_ready  = rdy;
    @(negedge clk);
    if (ec >= 0) chk("fifo_count", 64'(fifo_count), 64'(ec));
    chk("ch_grant", 64'(ch_grant), 64'(eg));
    for (int i = 0; i < 3; i++)
      if (eg[i]) exp_q.push_back({2'(i), ids[i*4 +: 4]});
  endtask

  initial begin
    rst         = 1'b1;
    ch_valid    = 3'b111;
    ch_entry_id = 12'hCBA;
    bank_ready  = 1'b1;
    #3;
    chk("rst_grant", 64'(ch_grant), 64'd0);
    chk("rst_bank_valid", 64'(bank_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ch_valid = 3'b000;
    rst      = 1'b0;
`ifdef XBAR_BANK_ARB_PERF_CNT_EN
    chk("perf_rst", 64'(grant_cnt), 64'd0);
`endif

    // All channels requesting, bank always ready.
    cyc(3'b111, 12'hCBA, 1'b1, 3'b001, 0);
    cyc(3'b111, 12'hCBA, 1'b1, 3'b010, 1);
    cyc(3'b111, 12'hCBA, 1'b1, 3'b100, 1);
    cyc(3'b111, 12'hCBA, 1'b1, 3'b001, 1);
    cyc(3'b111, 12'hCBA, 1'b1, 3'b010, 1);
    cyc(3'b111, 12'hCBA, 1'b1, 3'b100, 1);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 1);
    cyc(3'b000, 12'h000, 1'b0, 3'b000, 0);
    chk("drained_valid", 64'(bank_valid), 64'd0);

    // Fill to full with channel 0, then drain in order.
    cyc(3'b001, 12'h001, 1'b0, 3'b001, 0);
    cyc(3'b001, 12'h002, 1'b0, 3'b001, 1);
    cyc(3'b001, 12'h003, 1'b0, 3'b001, 2);
    cyc(3'b001, 12'h004, 1'b0, 3'b001, 3);
    cyc(3'b001, 12'h005, 1'b0, 3'b000, 4);
    cyc(3'b001, 12'h005, 1'b1, 3'b000, 4);
    cyc(3'b001, 12'h005, 1'b1, 3'b001, 3);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 3);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 2);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 1);
    cyc(3'b000, 12'h000, 1'b0, 3'b000, 0);

    // Simultaneous push and pop at occupancy 2 (rr now at channel 1).
    cyc(3'b010, 12'h070, 1'b0, 3'b010, 0);
    cyc(3'b100, 12'h800, 1'b0, 3'b100, 1);
    cyc(3'b001, 12'h009, 1'b1, 3'b001, 2);
    cyc(3'b000, 12'h000, 1'b0, 3'b000, 2);
    chk("head_ch", 64'(bank_ch), 64'd2);
    chk("head_id", 64'(bank_entry_id), 64'h8);
    cyc(3'b000, 12'h000, 1'b0, 3'b000, 2);
    chk("head_stable", 64'({bank_ch, bank_entry_id}), 64'h28);

    // rr at 2 with channels 0/1 requesting -> channel 0, then rr = 1.
    cyc(3'b010, 12'h0A0, 1'b0, 3'b010, 2);
    cyc(3'b011, 12'h0CB, 1'b0, 3'b001, 3);
    cyc(3'b011, 12'h0ED, 1'b1, 3'b000, 4);
    cyc(3'b011, 12'h0ED, 1'b1, 3'b010, 3);

    // Asynchronous reset with three entries held.
    cyc(3'b000, 12'h000, 1'b0, 3'b000, 3);
    chk("pre_rst_valid", 64'(bank_valid), 64'd1);
    #2;
    rst      = 1'b1;
    ch_valid = 3'b111;
    #1;
    chk("async_valid", 64'(bank_valid), 64'd0);
    chk("async_count", 64'(fifo_count), 64'd0);
    chk("async_grant", 64'(ch_grant), 64'd0);
    exp_q.delete();
    #1;
    ch_valid = 3'b000;
    rst      = 1'b0;
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 0);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 0);
    chk("post_rst_valid", 64'(bank_valid), 64'd0);
    cyc(3'b111, 12'h321, 1'b1, 3'b001, 0);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 1);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 0);

`ifdef XBAR_BANK_ARB_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    rst = 1'b0;
    for (int n = 0; n < 70000; n++)
      cyc(3'b010, 12'h030, 1'b1, 3'b010, -1);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, -1);
    cyc(3'b000, 12'h000, 1'b1, 3'b000, 0);
    chk("perf_ch1", 64'(grant_cnt[31:16]), 64'hFFFF);
    chk("perf_ch0", 64'(grant_cnt[15:0]), 64'h0);
    chk("perf_ch2", 64'(grant_cnt[47:32]), 64'h0);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
